// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants and types for the 1x3 router output FIFOs.
//   DATA_W       payload byte width
//   DEPTH        FIFO entries (power of two)
//   ADDR_W       log2(DEPTH); FIFO pointers carry one extra wrap bit
//   HDR_LEN_*    location of the payload-length field inside a header byte
//   HDR_ADDR_W   width of the destination-address field in a header byte
//   PKT_CNT_W    width of the in-flight packet counter (length field width)
//   fifo_entry_t one stored entry: header flag plus payload byte
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int PKT_CNT_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo_if.sv
// -----------------------------------------------------------------------------
// router_fifo_if
// Bundle between router_sync / the port reader (master) and one router_fifo
// (slave).
//   soft_reset  master->fifo  synchronous flush
//   write_enb   master->fifo  write strobe
//   read_enb    master->fifo  read strobe
//   lfd_state   master->fifo  1 = data_in is a packet header byte
//   data_in     master->fifo  byte to store
//   data_out    fifo->master  registered read data
//   full        fifo->master  DEPTH entries held
//   empty       fifo->master  zero entries held
//   pkt_busy    fifo->master  packet counter non-zero
//   fifo_count  fifo->master  occupancy (only with ROUTER_FIFO_CNT_EN)
// Configuration macro: ROUTER_FIFO_CNT_EN
// -----------------------------------------------------------------------------
interface router_fifo_if;
  import router_pkg::*;

  logic              soft_reset;
  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              pkt_busy;
`ifdef ROUTER_FIFO_CNT_EN
  logic [ADDR_W:0]   fifo_count;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_busy, fifo_count
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_busy, fifo_count
  );
`else
  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_busy
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_busy
  );
`endif

endinterface

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// Per-port output FIFO of the 1x3 router. Stores bytes written by router_sync
// together with a header flag, drains them to the port reader with one cycle
// of read latency, and tracks the remaining length of the packet being read
// so the port can report a packet in flight.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   bus     router_fifo_if.slave (strobes, data, flags, optional fifo_count)
// Configuration macro: ROUTER_FIFO_CNT_EN adds bus.fifo_count = wr_ptr - rd_ptr.
// -----------------------------------------------------------------------------
module router_fifo
  import router_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  router_fifo_if.slave  bus
);

  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [DATA_W-1:0]  data_out_p1;

  fifo_entry_t        mem [DEPTH];
  fifo_entry_t        rd_entry;

  logic               empty_w;
  logic               full_w;
  logic               wr_ok;
  logic               rd_ok;

  // Flags come from the registered pointers only; the extra MSB tells a
  // full ring apart from an empty one when the low bits match.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Each strobe is qualified on the pre-edge flags; a flush overrides both.
  assign wr_ok = bus.write_enb && !full_w  && !bus.soft_reset;
  assign rd_ok = bus.read_enb  && !empty_w && !bus.soft_reset;

  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  // Storage has no reset: a flush only rewinds the pointers.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= '{hdr: bus.lfd_state, data: bus.data_in};
    end
  end

  // Stage p1: pointers, registered read data and packet counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkt_cnt     <= '0;
      data_out_p1 <= '0;
    end else if (bus.soft_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkt_cnt     <= '0;
      data_out_p1 <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr      <= rd_ptr + 1'b1;
        data_out_p1 <= rd_entry.data;
        // A header reloads the counter with payload length plus the parity
        // byte; every following byte counts it down to zero.
        if (rd_entry.hdr) begin
          pkt_cnt <= rd_entry.data[HDR_LEN_MSB:HDR_LEN_LSB] + 1'b1;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.data_out = data_out_p1;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.pkt_busy = (pkt_cnt != '0);

`ifdef ROUTER_FIFO_CNT_EN
  assign bus.fifo_count = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo. A reference queue mirrors the FIFO
// contents; bytes popped by accepted reads go to an expected-output queue that
// is compared against data_out one cycle later. Flags, pkt_busy and (when
// ROUTER_FIFO_CNT_EN is defined) fifo_count are checked after every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_router_fifo;
  import router_pkg::*;

  logic clk;
  logic rst;

  router_fifo_if bus_if ();

  router_fifo dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [DATA_W:0]        mq [$];
  logic [DATA_W-1:0]      exp_q [$];
  logic [DATA_W-1:0]      m_dout;
  logic [PKT_CNT_W-1:0]   m_pkt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".empty"},    32'(bus_if.empty),    32'(mq.size() == 0));
    check_eq({tag, ".full"},     32'(bus_if.full),     32'(mq.size() == DEPTH));
    check_eq({tag, ".pkt_busy"}, 32'(bus_if.pkt_busy), 32'(m_pkt != 0));
    check_eq({tag, ".data_out"}, 32'(bus_if.data_out), 32'(m_dout));
`ifdef ROUTER_FIFO_CNT_EN
    check_eq({tag, ".count"},    32'(bus_if.fifo_count), 32'(mq.size()));
`endif
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_dout = '0;
    m_pkt  = '0;
  endtask

  // One clock cycle with the given strobes; the model is advanced on the
  // same pre-edge state the DUT sees, then outputs are compared after the edge.
  task automatic step(input string tag, input logic we, input logic re,
                      input logic lfd, input logic [DATA_W-1:0] din, input logic sr);
    logic           m_full;
    logic           m_empty;
    logic [DATA_W:0] e;
    @(negedge clk);
    bus_if.write_enb  = we;
    bus_if.read_enb   = re;
    bus_if.lfd_state  = lfd;
    bus_if.data_in    = din;
    bus_if.soft_reset = sr;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (sr) begin
      model_clear();
    end else begin
      if (re && !m_empty) begin
        e = mq.pop_front();
        exp_q.push_back(e[DATA_W-1:0]);
        if (e[DATA_W]) m_pkt = e[HDR_LEN_MSB:HDR_LEN_LSB] + 6'd1;
        else if (m_pkt != 0) m_pkt = m_pkt - 6'd1;
      end
      if (we && !m_full) mq.push_back({lfd, din});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    check_state(tag);
  endtask

  task automatic idle_inputs();
    bus_if.write_enb  = 1'b0;
    bus_if.read_enb   = 1'b0;
    bus_if.lfd_state  = 1'b0;
    bus_if.data_in    = '0;
    bus_if.soft_reset = 1'b0;
  endtask

  logic [DATA_W-1:0] pkt_bytes [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    idle_inputs();

    // Power-on reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    check_eq("reset.data_out_const", 32'(bus_if.data_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Packet: header 0D (length 3) + 3 payload + parity
    pkt_bytes[0] = 8'h0D; pkt_bytes[1] = 8'hA1; pkt_bytes[2] = 8'hA2;
    pkt_bytes[3] = 8'hA3; pkt_bytes[4] = 8'h5F;
    for (int i = 0; i < 5; i++) step("pkt_wr", 1'b1, 1'b0, (i == 0), pkt_bytes[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("pkt_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check_eq("pkt_seq", 32'(bus_if.data_out), 32'(pkt_bytes[i]));
      if (i == 0) check_eq("pkt_busy_hdr", 32'(bus_if.pkt_busy), 32'h1);
    end
    check_eq("pkt_busy_end", 32'(bus_if.pkt_busy), 32'h0);

    // Fill to full, overflow write dropped, drain in order
    for (int i = 0; i < DEPTH; i++) step("fill_wr", 1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
    check_eq("fill_full", 32'(bus_if.full), 32'h1);
    step("fill_ovf", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step("fill_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check_eq("fill_seq", 32'(bus_if.data_out), 32'(i));
    end
    check_eq("fill_empty", 32'(bus_if.empty), 32'h1);

    // Simultaneous read+write at full: write of EE dropped
    for (int i = 0; i < DEPTH; i++) step("sf_wr", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
    step("sf_rw", 1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    check_eq("sf_full", 32'(bus_if.full), 32'h0);
`ifdef ROUTER_FIFO_CNT_EN
    check_eq("sf_count", 32'(bus_if.fifo_count), 32'd15);
`endif
    for (int i = 0; i < DEPTH - 1; i++) begin
      step("sf_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check_eq("sf_not_ee", 32'(bus_if.data_out == 8'hEE), 32'h0);
    end
    step("sf_rd_extra", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Simultaneous read+write at empty: read ignored, write stored
    step("se_rw", 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    check_eq("se_empty", 32'(bus_if.empty), 32'h0);
    check_eq("se_hold", 32'(bus_if.data_out), 32'(8'h4F));
    step("se_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("se_data", 32'(bus_if.data_out), 32'(8'h33));

    // Flush mid-packet with a coincident write
    step("fl_wr", 1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
    for (int i = 0; i < 4; i++) step("fl_wr", 1'b1, 1'b0, 1'b0, 8'(8'hB0 + i), 1'b0);
    step("fl_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("fl_busy", 32'(bus_if.pkt_busy), 32'h1);
    step("fl_sr", 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
    check_eq("fl_empty", 32'(bus_if.empty), 32'h1);
    check_eq("fl_pkt", 32'(bus_if.pkt_busy), 32'h0);
    check_eq("fl_dout", 32'(bus_if.data_out), 32'h0);
    step("fl_rd_empty", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step("fl_wr2", 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    step("fl_rd2", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("fl_after", 32'(bus_if.data_out), 32'(8'h55));

    // Random traffic with occasional headers and flushes
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset mid-packet, asserted between clock edges
    step("ar_wr", 1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
    step("ar_wr", 1'b1, 1'b0, 1'b0, 8'hC1, 1'b0);
    step("ar_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_state("arst");
    @(negedge clk);
    rst = 1'b0;
    step("ar_post", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
